// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, fixed-latency memory between instruction fetch
// and the data memory stage. One access is outstanding at a time. Fetch and
// data alternate when both are eligible.
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_cancel,
    input  logic              halt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    // data side
    input  logic              dm_req,
    input  logic              dm_wr,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    // memory side
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Owner / last_grant encoding: 0 = data, 1 = fetch
    localparam logic OWN_DATA  = 1'b0;
    localparam logic OWN_FETCH = 1'b1;

    localparam int              CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last_grant;
    logic             squash;

    logic if_elig, dm_elig, grant_if, grant_dm;

    // Eligibility and alternating tie-break between the two requesters
    always_comb begin
        if_elig  = if_req & ~halt & ~if_cancel;
        dm_elig  = dm_req;
        grant_if = if_elig & (~dm_elig | (last_grant == OWN_DATA));
        grant_dm = dm_elig & ~grant_if;
    end

    // Stalls follow the request until the matching done pulse
    always_comb begin
        if_stall = if_req & ~if_done;
        dm_stall = dm_req & ~dm_done;
    end

    // Access sequencer: grant in IDLE, count down latency in BUSY, respond in RESP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            owner      <= OWN_DATA;
            last_grant <= OWN_DATA;
            squash     <= 1'b0;
            mem_en     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_if || grant_dm) begin
                        owner      <= grant_if;
                        last_grant <= grant_if;
                        mem_en     <= 1'b1;
                        mem_addr   <= grant_if ? if_addr : dm_addr;
                        mem_wr     <= grant_dm & dm_wr;
                        mem_wdata  <= grant_dm ? dm_wdata : '0;
                        cnt        <= CNT_INIT;
                        state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // A redirect while the fetch is in flight discards its result
                    if (owner == OWN_FETCH && if_cancel)
                        squash <= 1'b1;
                    if (cnt != '0)
                        cnt <= cnt - 1'b1;
                    else
                        state <= S_RESP;
                end
                S_RESP: begin
                    squash <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response registers: capture read data and pulse the owner's done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_done  <= 1'b0;
            dm_done  <= 1'b0;
            if_rdata <= '0;
            dm_rdata <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            if (state == S_BUSY && cnt == '0) begin
                if (owner == OWN_FETCH) begin
                    if (!squash) begin
                        if_done  <= 1'b1;
                        if_rdata <= mem_rdata;
                    end
                end else begin
                    dm_done <= 1'b1;
                    // mem_wr still holds the owner's direction until the next grant
                    if (!mem_wr)
                        dm_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table of single transactions plus
// hand sequences for arbitration, squash, halt and asynchronous reset.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        clk, rst;
    logic        if_req, if_cancel, halt, if_done, if_stall;
    logic [15:0] if_addr, if_rdata;
    logic        dm_req, dm_wr, dm_done, dm_stall;
    logic [15:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.MEM_LATENCY(L), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel), .halt(halt),
        .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: background pattern addr ^ A5B5, writes land at issue
    logic [15:0] mem_arr [0:65535];
    logic [15:0] rd_addr;

    function automatic logic [15:0] pat(input logic [15:0] a);
        return a ^ 16'hA5B5;
    endfunction

    initial begin
        rd_addr = 16'h0;
        for (int i = 0; i < 65536; i++) mem_arr[i] = pat(16'(i));
    end

    always @(posedge clk) begin
        if (mem_en) begin
            rd_addr <= mem_addr;
            if (mem_wr) mem_arr[mem_addr] <= mem_wdata;
        end
    end

    assign mem_rdata = mem_arr[rd_addr];

    // Scoreboard and counters
    logic [15:0] if_q[$], dm_q[$];
    logic        order_log[$];   // 1 = fetch done, 0 = data done
    int          nvec = 0, nerr = 0;
    int          issue_cnt = 0, if_done_cnt = 0, dm_done_cnt = 0;
    logic        prev_en = 1'b0;
    logic [15:0] last_if_rd = 16'h0, last_dm_rd = 16'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Output monitor: pops expected read data on each done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (mem_en) begin
                issue_cnt++;
                check("mem_en_single_cycle", {31'b0, prev_en}, 0);
            end
            prev_en = mem_en;
            if (if_done) begin
                if_done_cnt++;
                order_log.push_back(1'b1);
                check("if_done_expected", {31'b0, if_q.size() != 0}, 1);
                if (if_q.size() != 0) check("if_rdata", {16'b0, if_rdata}, {16'b0, if_q.pop_front()});
            end
            if (dm_done) begin
                dm_done_cnt++;
                order_log.push_back(1'b0);
                check("dm_done_expected", {31'b0, dm_q.size() != 0}, 1);
                if (dm_q.size() != 0) check("dm_rdata", {16'b0, dm_rdata}, {16'b0, dm_q.pop_front()});
            end
        end
    end

    typedef struct {
        logic        is_fetch;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vt[8];

    // One isolated transaction: checks issue strobe, stall and done latency
    task automatic run_txn(input vec_t v);
        int   n;
        logic seen;
        @(posedge clk); #1;
        if (v.is_fetch) begin
            if_req = 1'b1; if_addr = v.addr;
            if_q.push_back(v.exp); last_if_rd = v.exp;
        end else begin
            dm_req = 1'b1; dm_wr = v.wr; dm_addr = v.addr; dm_wdata = v.wdata;
            if (v.wr) dm_q.push_back(last_dm_rd);
            else begin dm_q.push_back(v.exp); last_dm_rd = v.exp; end
        end
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk); n++;
            if (n == 2) begin
                check("issue_mem_en", {31'b0, mem_en}, 1);
                check("issue_mem_addr", {16'b0, mem_addr}, {16'b0, v.addr});
                check("issue_mem_wr", {31'b0, mem_wr}, {31'b0, ~v.is_fetch & v.wr});
                check("issue_mem_wdata", {16'b0, mem_wdata}, v.is_fetch ? 32'h0 : {16'b0, v.wdata});
            end
            seen = v.is_fetch ? if_done : dm_done;
            check("stall", {31'b0, v.is_fetch ? if_stall : dm_stall}, {31'b0, ~seen});
        end
        check("done_latency", n, L + 2);
        @(posedge clk); #1;
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        int bi, bf, bd, n, d;
        logic found;

        vt[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5};
        vt[1] = '{1'b0, 1'b1, 16'h0100, 16'h1234, 16'h0000};
        vt[2] = '{1'b0, 1'b0, 16'h0100, 16'h0000, 16'h1234};
        vt[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h1234};
        vt[4] = '{1'b0, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000};
        vt[5] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'hBEEF};
        vt[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hA5B5};
        vt[7] = '{1'b0, 1'b0, 16'h0300, 16'h0000, 16'hA6B5};

        rst = 1'b0; if_req = 1'b0; if_addr = 16'h0; if_cancel = 1'b0; halt = 1'b0;
        dm_req = 1'b0; dm_wr = 1'b0; dm_addr = 16'h0; dm_wdata = 16'h0;

        // Reset state
        #3;
        check("rst_mem_en", {31'b0, mem_en}, 0);
        check("rst_mem_addr", {16'b0, mem_addr}, 0);
        check("rst_if_done", {31'b0, if_done}, 0);
        check("rst_dm_done", {31'b0, dm_done}, 0);
        check("rst_if_rdata", {16'b0, if_rdata}, 0);
        check("rst_dm_rdata", {16'b0, dm_rdata}, 0);
        #9 rst = 1'b1;

        // Table of isolated transactions
        for (int i = 0; i < 8; i++) run_txn(vt[i]);

        // Both requesters held: grants alternate, fetch first since data went last
        @(posedge clk); #1;
        order_log.delete();
        bf = if_done_cnt; bd = dm_done_cnt;
        if_req = 1'b1; if_addr = 16'h0200;
        dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0300;
        for (int i = 0; i < 4; i++) begin
            if_q.push_back(pat(16'h0200));
            dm_q.push_back(pat(16'h0300));
        end
        last_if_rd = pat(16'h0200); last_dm_rd = pat(16'h0300);
        n = 0; d = 0;
        while (d < 8 && n < 200) begin
            @(negedge clk); n++;
            if (if_done) d++;
            if (dm_done) d++;
        end
        if_req = 1'b0; dm_req = 1'b0;
        check("arb_done_count", d, 8);
        repeat (L + 4) @(posedge clk); #1;
        check("arb_log_size", order_log.size(), 8);
        for (int i = 0; i < 8 && i < order_log.size(); i++)
            check("arb_order", {31'b0, order_log[i]}, {31'b0, (i % 2) == 0});
        check("arb_if_dones", if_done_cnt - bf, 4);
        check("arb_dm_dones", dm_done_cnt - bd, 4);

        // Squashed fetch: issues, but no done and rdata kept
        @(posedge clk); #1;
        bi = issue_cnt; bf = if_done_cnt;
        if_req = 1'b1; if_addr = 16'h0020;
        @(posedge clk);
        #1 if_cancel = 1'b1; if_req = 1'b0;
        @(posedge clk); #1 if_cancel = 1'b0;
        repeat (L + 4) @(posedge clk); #1;
        check("squash_issued", issue_cnt - bi, 1);
        check("squash_no_done", if_done_cnt - bf, 0);
        check("squash_rdata_kept", {16'b0, if_rdata}, {16'b0, last_if_rd});
        run_txn('{1'b1, 1'b0, 16'h0040, 16'h0000, 16'hA5F5});

        // Halt: data write goes through, fetch waits until halt drops
        @(posedge clk); #1;
        bi = issue_cnt; bf = if_done_cnt;
        halt = 1'b1;
        if_req = 1'b1; if_addr = 16'h0050; if_q.push_back(pat(16'h0050));
        dm_req = 1'b1; dm_wr = 1'b1; dm_addr = 16'h0060; dm_wdata = 16'h5555;
        dm_q.push_back(last_dm_rd);
        found = 1'b0; n = 0;
        while (!found && n < 40) begin @(negedge clk); n++; found = dm_done; end
        check("halt_dm_done", {31'b0, found}, 1);
        @(posedge clk); #1 dm_req = 1'b0;
        repeat (6) @(posedge clk); #1;
        check("halt_one_issue", issue_cnt - bi, 1);
        check("halt_no_fetch", if_done_cnt - bf, 0);
        check("halt_if_stall", {31'b0, if_stall}, 1);
        halt = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 40) begin @(negedge clk); n++; found = if_done; end
        check("halt_fetch_resumes", {31'b0, found}, 1);
        last_if_rd = pat(16'h0050);
        @(posedge clk); #1 if_req = 1'b0;

        // Asynchronous reset in the middle of a fetch
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = 16'h0070;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
        #1 if_req = 1'b0;
        #1;
        check("arst_mem_en", {31'b0, mem_en}, 0);
        check("arst_mem_wr", {31'b0, mem_wr}, 0);
        check("arst_mem_addr", {16'b0, mem_addr}, 0);
        check("arst_mem_wdata", {16'b0, mem_wdata}, 0);
        check("arst_if_done", {31'b0, if_done}, 0);
        check("arst_dm_done", {31'b0, dm_done}, 0);
        check("arst_if_rdata", {16'b0, if_rdata}, 0);
        check("arst_dm_rdata", {16'b0, dm_rdata}, 0);
        last_if_rd = 16'h0; last_dm_rd = 16'h0;
        bi = issue_cnt; bf = if_done_cnt; bd = dm_done_cnt;
        repeat (2) @(posedge clk); #1 rst = 1'b1;
        repeat (L + 4) @(posedge clk); #1;
        check("arst_no_stale_if_done", if_done_cnt - bf, 0);
        check("arst_no_stale_dm_done", dm_done_cnt - bd, 0);
        check("arst_no_issue", issue_cnt - bi, 0);
        run_txn('{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hA5A5});

        repeat (2) @(posedge clk); #1;
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
